keypad_emulator: RTL and testbench
==================================

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 Parameter BOUNCE_LEN, default 4: number of bounce-toggle cycles at press and at release (used only with KEYPAD_EMU_BOUNCE_EN).
REQ-002 Parameter HOLD_W, default 8: width of HoldCycles.
REQ-003 Reset is synchronous and active-low; one clock.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 ColOut  input  4  column drive from the scanner, active-low; bit 3 = column 0.
REQ-007 Row  output  4  row lines to the scanner, active-low; bit 3 = row 0; 4'b1111 when no contact.
REQ-008 KeyCode  input  4  key to press: [3:2] row index, [1:0] column index.
REQ-009 HoldCycles  input  HOLD_W  number of stable-press clk cycles.
REQ-010 KeyValid  input  1  press request.
REQ-011 KeyAccept  output  1  ready; a request is taken when KeyValid && KeyAccept.
REQ-012 Busy  output  1  high in every state except IDLE.
REQ-013 PressDone  output  1  one-cycle pulse when the release completes.

Function
REQ-014 States: IDLE, BOUNCE_ON, HOLD, BOUNCE_OFF, DONE.
REQ-015 IDLE: KeyAccept=1; on handshake, latch KeyCode and HoldCycles, then go to BOUNCE_ON (or HOLD without the macro).
REQ-016 KeyCode and HoldCycles changes after acceptance have no effect until the next acceptance.
REQ-017 Internal "contact" flag: 0 in IDLE and DONE; 1 in HOLD; toggles every cycle in BOUNCE_ON and BOUNCE_OFF, starting at 1.
REQ-018 Row is combinational from ColOut and the registered contact flag and latched key.
REQ-019 Row[3-r] = 0 iff contact=1 and ColOut[3-c]=0; all other Row bits are 1. There is zero-cycle latency from ColOut to Row.
REQ-020 ColOut=4'b1111 produces Row=4'b1111 regardless of state.
REQ-021 Multiple low ColOut bits are handled by the same per-bit rule.
REQ-022 BOUNCE_ON lasts exactly BOUNCE_LEN cycles, then goes to HOLD.
REQ-023 HOLD lasts exactly max(HoldCycles,1) cycles; HoldCycles=0 is treated as 1.
REQ-024 HOLD then goes to BOUNCE_OFF (or DONE without the macro).
REQ-025 BOUNCE_OFF lasts exactly BOUNCE_LEN cycles, then goes to DONE.
REQ-026 DONE lasts one cycle with PressDone=1, then goes to IDLE.
REQ-027 KeyAccept=0 in DONE, so back-to-back presses are separated by at least one IDLE cycle.
REQ-028 The internal counter is HOLD_W bits wide, counts down, is loaded on each state entry and never wraps.
REQ-029 With HoldCycles=all-ones, HOLD lasts exactly 2^HOLD_W-1 cycles.

Reset
REQ-030 On rst=0 at a clock edge, return to IDLE with contact=0, counter=0 and the latched key=0.
REQ-031 After reset, outputs are Row=4'b1111, KeyAccept=1, Busy=0, PressDone=0.
REQ-032 Reset mid-press (any state) releases the key at that edge; no PressDone is issued.

Configuration
REQ-033 Macro KEYPAD_EMU_BOUNCE_EN defined: BOUNCE_ON and BOUNCE_OFF are present per REQ-017, REQ-022 and REQ-025.
REQ-034 Macro KEYPAD_EMU_BOUNCE_EN undefined: the bounce states and the BOUNCE_LEN logic are removed; the sequence is IDLE -> HOLD -> DONE -> IDLE.

Structure
REQ-035 Shared package keypad_pkg holds the state encoding and the active-low one-hot constants COL0..COL3 and ROW0..ROW3 (4'b0111, 4'b1011, 4'b1101, 4'b1110).
REQ-036 The package is shared with the keypad scanner.
REQ-037 Sub-module keypad_row_decode implements the combinational contact/ColOut/key -> Row mapping of REQ-019.

Verification
REQ-038 Macro off; KeyCode=4'b0110 (row 1, col 2), HoldCycles=3 -> Busy rises the next cycle; Row=4'b1011 only while ColOut=4'b1101 for 3 cycles; PressDone pulses once; KeyAccept returns 1 one cycle later.
REQ-039 Macro off; HoldCycles=0, KeyCode=4'b0000 -> contact lasts exactly 1 cycle; Row=4'b0111 only when ColOut=4'b0111.
REQ-040 Macro on, BOUNCE_LEN=4, HoldCycles=2 -> contact pattern is 1,0,1,0,1,1,1,0,1,0,DONE; total Busy time is 11 cycles.
REQ-041 Request KeyValid while Busy -> KeyAccept=0 and the request is ignored; held KeyValid is accepted on the first IDLE cycle after DONE.
REQ-042 rst=0 asserted during HOLD -> at the next edge Row=4'b1111, state IDLE, no PressDone.
REQ-043 Sweep all 16 KeyCode values against all 4 single-low ColOut patterns -> exactly one Row bit low per matching pair; Row=4'b1111 otherwise.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: emulator state encoding and active-low one-hot
// row/column line constants, common to the keypad emulator and the scanner.
package keypad_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_ON  = 3'd1,
    HOLD       = 3'd2,
    BOUNCE_OFF = 3'd3,
    DONE       = 3'd4
  } state_e;

  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;
  localparam logic [3:0] COL3 = 4'b1110;

  localparam logic [3:0] ROW0 = 4'b0111;
  localparam logic [3:0] ROW1 = 4'b1011;
  localparam logic [3:0] ROW2 = 4'b1101;
  localparam logic [3:0] ROW3 = 4'b1110;

  function automatic logic [3:0] row_line(input logic [1:0] r);
    unique case (r)
      2'd0:    return ROW0;
      2'd1:    return ROW1;
      2'd2:    return ROW2;
      default: return ROW3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Scanner-facing and request-facing signals of the keypad emulator.
// master = scanner/test driver side, slave = the emulator itself.
interface keypad_emulator_if #(
  parameter int HOLD_W = 8
);
  logic [3:0]        ColOut;
  logic [3:0]        Row;
  logic [3:0]        KeyCode;
  logic [HOLD_W-1:0] HoldCycles;
  logic              KeyValid;
  logic              KeyAccept;
  logic              Busy;
  logic              PressDone;

  modport master (
    output ColOut, KeyCode, HoldCycles, KeyValid,
    input  Row, KeyAccept, Busy, PressDone
  );

  modport slave (
    input  ColOut, KeyCode, HoldCycles, KeyValid,
    output Row, KeyAccept, Busy, PressDone
  );
endinterface

// File: rtl/keypad_row_decode.sv
// Combinational contact/ColOut/key -> Row mapping; a row line is pulled low
// only while the key is in contact and its column is being driven low.
module keypad_row_decode
  import keypad_pkg::*;
(
  input  logic       contact_i,
  input  logic [3:0] col_i,
  input  logic [3:0] key_i,
  output logic [3:0] row_o
);

  // Column c is carried on ColOut bit 3-c, i.e. the bitwise inverse of c.
  logic [1:0] col_idx;
  assign col_idx = ~key_i[1:0];

  assign row_o = (contact_i && !col_i[col_idx]) ? row_line(key_i[3:2]) : 4'b1111;

endmodule

// File: rtl/keypad_emulator.sv
// Keypad press emulator: accepts a key/duration request and presents the
// contact to a row/column scanner. Define KEYPAD_EMU_BOUNCE_EN for contact bounce.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int BOUNCE_LEN = 4,
  parameter int HOLD_W     = 8
) (
  input logic               clk,
  input logic               rst,
  keypad_emulator_if.slave  bus
);

  if (BOUNCE_LEN < 1 || BOUNCE_LEN >= 2**HOLD_W) begin : g_bad_bounce_len
    $error("BOUNCE_LEN must be in 1 .. 2**HOLD_W-1");
  end

  localparam logic [HOLD_W-1:0] CNT_ONE = HOLD_W'(1);

  state_e            state_q;
  logic [HOLD_W-1:0] cnt_q;
  logic              contact_q;
  logic [3:0]        key_q;
  logic              accept_q;
  logic              busy_q;
  logic              done_q;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam logic [HOLD_W-1:0] BOUNCE_CNT = HOLD_W'(BOUNCE_LEN);
  logic [HOLD_W-1:0] hold_q;
`endif

  // A zero hold request still produces one cycle of stable contact.
  function automatic logic [HOLD_W-1:0] hold_len(input logic [HOLD_W-1:0] h);
    return (h == '0) ? CNT_ONE : h;
  endfunction

  // NOTE: every register here is assigned with <= so all of them update
  // together from the pre-edge values; a blocking = would leak this cycle's
  // new value into the decisions that follow it in the same block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      contact_q <= 1'b0;
      key_q     <= '0;
      accept_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      hold_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.KeyValid && accept_q) begin
            key_q     <= bus.KeyCode;
            contact_q <= 1'b1;
            accept_q  <= 1'b0;
            busy_q    <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
            hold_q    <= bus.HoldCycles;
            cnt_q     <= BOUNCE_CNT;
            state_q   <= BOUNCE_ON;
`else
            cnt_q     <= hold_len(bus.HoldCycles);
            state_q   <= HOLD;
`endif
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE_ON: begin
          if (cnt_q == CNT_ONE) begin
            cnt_q     <= hold_len(hold_q);
            contact_q <= 1'b1;
            state_q   <= HOLD;
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            contact_q <= ~contact_q;
          end
        end
`endif
        HOLD: begin
          if (cnt_q == CNT_ONE) begin
`ifdef KEYPAD_EMU_BOUNCE_EN
            cnt_q     <= BOUNCE_CNT;
            contact_q <= 1'b1;
            state_q   <= BOUNCE_OFF;
`else
            cnt_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
`ifdef KEYPAD_EMU_BOUNCE_EN
        BOUNCE_OFF: begin
          if (cnt_q == CNT_ONE) begin
            cnt_q     <= '0;
            contact_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            cnt_q     <= cnt_q - CNT_ONE;
            contact_q <= ~contact_q;
          end
        end
`endif
        DONE: begin
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
          accept_q <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          cnt_q     <= '0;
          contact_q <= 1'b0;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
          accept_q  <= 1'b1;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign bus.KeyAccept = accept_q;
  assign bus.Busy      = busy_q;
  assign bus.PressDone = done_q;

  keypad_row_decode u_row_decode (
    .contact_i (contact_q),
    .col_i     (bus.ColOut),
    .key_i     (key_q),
    .row_o     (bus.Row)
  );

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: randomized presses compared against
// a contact-sequence model built from press rules; follows KEYPAD_EMU_BOUNCE_EN.
module tb_keypad_emulator;

  localparam int BL = 4;
  localparam int HW = 8;
`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam int B = BL;
`else
  localparam int B = 0;
`endif

  typedef bit bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_emulator_if #(.HOLD_W(HW)) bus ();

  keypad_emulator #(.BOUNCE_LEN(BL), .HOLD_W(HW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Contact value for each busy cycle before DONE: bounce-on, hold, bounce-off.
  function automatic bq_t build(input int hold);
    bq_t q;
    int  h = (hold == 0) ? 1 : hold;
    for (int i = 0; i < B; i++) q.push_back(i % 2 == 0);
    for (int i = 0; i < h; i++) q.push_back(1'b1);
    for (int i = 0; i < B; i++) q.push_back(i % 2 == 0);
    return q;
  endfunction

  function automatic logic [3:0] exp_row(input bit contact, input logic [3:0] code,
                                         input logic [3:0] col);
    logic [3:0] e = 4'b1111;
    int r  = int'(code[3:2]);
    int ci = 3 - int'(code[1:0]);
    for (int i = 0; i < 4; i++)
      if (contact && col[ci] == 1'b0 && i == r) e[3-i] = 1'b0;
    return e;
  endfunction

  function automatic logic [3:0] match_col(input logic [3:0] code);
    logic [3:0] one = 4'b1000;
    return ~(one >> code[1:0]);
  endfunction

  // mode 0: random mix, 1: fixed pattern, 2: sweep of single-low columns
  function automatic logic [3:0] pick(input int mode, input logic [3:0] fix,
                                      input logic [3:0] code, input int i);
    logic [3:0] one = 4'b1000;
    if (mode == 1) return fix;
    if (mode == 2) return ~(one >> (i % 4));
    case ($urandom_range(0, 3))
      0:       return 4'b1111;
      1:       return match_col(code);
      2:       return 4'($urandom);
      default: return ~(one >> $urandom_range(0, 3));
    endcase
  endfunction

  task automatic accept(input logic [3:0] code, input int hold, input string tag);
    bus.ColOut     = 4'b1111;
    bus.KeyCode    = code;
    bus.HoldCycles = HW'(hold);
    bus.KeyValid   = 1'b1;
    #1;
    n_cmp++;
    if ({bus.Busy, bus.KeyAccept} !== 2'b01) begin
      n_err++;
      $display("FAIL %s idle_before: {Busy,KeyAccept} got %b want 01", tag, {bus.Busy, bus.KeyAccept});
    end
    @(negedge clk);
  endtask

  // Runs from the first busy cycle through DONE and the following IDLE cycle.
  task automatic body(input logic [3:0] code, input int hold, input int mode,
                      input logic [3:0] fix, input bit chain, input logic [3:0] ncode,
                      input int nhold, input string tag);
    bq_t pat = build(hold);
    if (chain) begin
      bus.KeyValid   = 1'b1;
      bus.KeyCode    = ncode;
      bus.HoldCycles = HW'(nhold);
    end else begin
      bus.KeyValid   = 1'b0;
      bus.KeyCode    = 4'($urandom);
      bus.HoldCycles = HW'($urandom);
    end
    for (int i = 0; i < pat.size(); i++) begin
      bus.ColOut = pick(mode, fix, code, i);
      #1;
      n_cmp++;
      if (bus.Row !== exp_row(pat[i], code, bus.ColOut)) begin
        n_err++;
        $display("FAIL %s row[%0d]: col %b got %b want %b", tag, i, bus.ColOut, bus.Row,
                 exp_row(pat[i], code, bus.ColOut));
      end
      n_cmp++;
      if ({bus.Busy, bus.KeyAccept, bus.PressDone} !== 3'b100) begin
        n_err++;
        $display("FAIL %s busy_flags[%0d]: got %b want 100", tag, i,
                 {bus.Busy, bus.KeyAccept, bus.PressDone});
      end
      @(negedge clk);
    end
    bus.ColOut = match_col(code);
    #1;
    n_cmp++;
    if ({bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone} !== 7'b1111_101) begin
      n_err++;
      $display("FAIL %s done: {Row,Busy,KeyAccept,PressDone} got %b want 1111101", tag,
               {bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone});
    end
    @(negedge clk);
    bus.ColOut = match_col(code);
    #1;
    n_cmp++;
    if ({bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone} !== 7'b1111_010) begin
      n_err++;
      $display("FAIL %s idle_after: {Row,Busy,KeyAccept,PressDone} got %b want 1111010", tag,
               {bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ColOut = 4'b0000;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone} !== 7'b1111_010) begin
      n_err++;
      $display("FAIL reset_state: {Row,Busy,KeyAccept,PressDone} got %b want 1111010",
               {bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone});
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone} !== 7'b1111_010) begin
      n_err++;
      $display("FAIL after_reset: {Row,Busy,KeyAccept,PressDone} got %b want 1111010",
               {bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone});
    end
    @(negedge clk);
  endtask

  task automatic test_directed();
    accept(4'b0110, 3, "r1c2_h3");
    body(4'b0110, 3, 1, 4'b1101, 1'b0, 4'h0, 0, "r1c2_h3");
    accept(4'b0000, 0, "r0c0_h0");
    body(4'b0000, 0, 1, 4'b0111, 1'b0, 4'h0, 0, "r0c0_h0");
    accept(4'b0110, 2, "r1c2_wrongcol");
    body(4'b0110, 2, 1, 4'b1011, 1'b0, 4'h0, 0, "r1c2_wrongcol");
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      logic [3:0] code = 4'($urandom);
      int         hold = $urandom_range(0, 6);
      accept(code, hold, $sformatf("rand%0d", n));
      body(code, hold, 0, 4'h0, 1'b0, 4'h0, 0, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_hold_max();
    accept(4'b1011, 255, "hold_max");
    body(4'b1011, 255, 0, 4'h0, 1'b0, 4'h0, 0, "hold_max");
  endtask

  task automatic test_back_to_back();
    accept(4'b1001, 2, "b2b_first");
    body(4'b1001, 2, 0, 4'h0, 1'b1, 4'b0111, 3, "b2b_first");
    body(4'b0111, 3, 0, 4'h0, 1'b0, 4'h0, 0, "b2b_second");
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 16; k++) begin
      accept(4'(k), 4, $sformatf("sweep%0d", k));
      body(4'(k), 4, 2, 4'h0, 1'b0, 4'h0, 0, $sformatf("sweep%0d", k));
    end
  endtask

  task automatic test_reset_mid_hold();
    logic [3:0] code = 4'b1110;
    accept(code, 10, "rst_hold");
    bus.KeyValid = 1'b0;
    bus.ColOut   = match_col(code);
    repeat (B + 2) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.Row !== 4'b1110) begin
      n_err++;
      $display("FAIL rst_hold_pressed: Row got %b want 1110", bus.Row);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone} !== 7'b1111_010) begin
      n_err++;
      $display("FAIL rst_hold_released: {Row,Busy,KeyAccept,PressDone} got %b want 1111010",
               {bus.Row, bus.Busy, bus.KeyAccept, bus.PressDone});
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if ({bus.Row, bus.Busy, bus.PressDone} !== 6'b1111_00) begin
        n_err++;
        $display("FAIL rst_hold_quiet[%0d]: {Row,Busy,PressDone} got %b want 111100", i,
                 {bus.Row, bus.Busy, bus.PressDone});
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.ColOut     = 4'b1111;
    bus.KeyCode    = 4'h0;
    bus.HoldCycles = '0;
    bus.KeyValid   = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_hold_max();
    test_back_to_back();
    test_sweep();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
